// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Counter/index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-producer side and display side of the scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic                    load;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output digits, dp, digit_mask, load,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  digits, dp, digit_mask, load,
    output seg, dig_en, frame_done
  );
endinterface

// File: rtl/segment7.sv
// BCD to seven-segment decoder, active-high, bit 7 (dp) always 0.
module segment7
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 8'h3f;
      4'd1: seg = 8'h06;
      4'd2: seg = 8'h5b;
      4'd3: seg = 8'h4f;
      4'd4: seg = 8'h66;
      4'd5: seg = 8'h6d;
      4'd6: seg = 8'h7d;
      4'd7: seg = 8'h07;
      4'd8: seg = 8'h7f;
      4'd9: seg = 8'h67;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display
// with double-buffered digits swapped only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic          clk,
  input logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = idx_width(REFRESH_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [IDX_W-1:0]            idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0]     shadow_digits_reg, act_digits_reg, act_digits_next;
  logic [NUM_DIGITS-1:0]       shadow_dp_reg, act_dp_reg, act_dp_next;
  logic                        pending_reg, pending_next;
  logic [SEG_W-1:0]            seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]       dig_en_reg, dig_en_next;
  logic                        frame_done_reg, frame_done_next;
  logic                        boundary;
  logic                        show;
  logic [BCD_W-1:0]            next_bcd [NUM_DIGITS];
  logic [SEG_W-1:0]            dec_seg;

  always_comb begin
    boundary = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_LAST)
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);

    // A load on the boundary cycle bypasses the shadow straight into active.
    act_digits_next = act_digits_reg;
    act_dp_next     = act_dp_reg;
    pending_next    = pending_reg;
    if (boundary) begin
      pending_next = 1'b0;
      if (bus.load) begin
        act_digits_next = bus.digits;
        act_dp_next     = bus.dp;
      end else if (pending_reg) begin
        act_digits_next = shadow_digits_reg;
        act_dp_next     = shadow_dp_reg;
      end
    end else if (bus.load) begin
      pending_next = 1'b1;
    end
  end

  // Outputs are computed from next-state values and registered, so they line
  // up with cnt/idx while having no combinational path from any input.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign next_bcd[gi]    = act_digits_next[4*gi +: 4];
    assign dig_en_next[gi] = show && (idx_next == IDX_W'(gi));
  end

  segment7 u_dec (
    .bcd (next_bcd[idx_next]),
    .seg (dec_seg)
  );

  always_comb begin
    show            = (int'(cnt_next) >= BLANK_CYCLES) && bus.digit_mask[idx_next];
    seg_next        = show ? {act_dp_next[idx_next], dec_seg[6:0]} : SEG_BLANK;
    frame_done_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg           <= '0;
      idx_reg           <= '0;
      pending_reg       <= 1'b0;
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      act_digits_reg    <= '0;
      act_dp_reg        <= '0;
      seg_reg           <= SEG_BLANK;
      dig_en_reg        <= '0;
      frame_done_reg    <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      pending_reg    <= pending_next;
      act_digits_reg <= act_digits_next;
      act_dp_reg     <= act_dp_next;
      seg_reg        <= seg_next;
      dig_en_reg     <= dig_en_next;
      frame_done_reg <= frame_done_next;
      if (bus.load) begin
        shadow_digits_reg <= bus.digits;
        shadow_dp_reg     <= bus.dp;
      end
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.dig_en     = dig_en_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mc = 0;
  bit   started = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference scan position: cycles since the last reset edge.
  always @(posedge clk) begin
    if (!rst_n) mc <= 0;
    else        mc <= mc + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      assert (bus.frame_done === ((mc % 32) == 31)) else begin
        errors++;
        $error("FAIL inv_frame_done: observed %b expected %b (t=%0d)", bus.frame_done, (mc % 32) == 31, mc);
      end
      checks++;
      assert ($onehot0(bus.dig_en)) else begin
        errors++;
        $error("FAIL inv_onehot: observed %b expected zero or one-hot", bus.dig_en);
      end
      if ((mc % 8) < 2) begin
        checks++;
        assert (bus.dig_en === 4'b0000) else begin
          errors++;
          $error("FAIL inv_blank: observed %b expected 0000 (t=%0d)", bus.dig_en, mc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] en, input logic [7:0] sg);
    chk({tag, "_en"}, {4'b0, bus.dig_en}, {4'b0, en});
    chk({tag, "_seg"}, bus.seg, sg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_load(input int n, input logic [15:0] d, input logic [3:0] p);
    goto(n);
    bus.load   = 1'b1;
    bus.digits = d;
    bus.dp     = p;
    tick();
    bus.load   = 1'b0;
  endtask

  task automatic do_reset(input bit check_outputs);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    if (check_outputs) begin
      slot("reset", 4'b0000, 8'h00);
      chk("reset_frame_done", {7'b0, bus.frame_done}, 8'h00);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.digits     = '0;
    bus.dp         = '0;
    bus.digit_mask = 4'b1111;

    // Idle scan after reset, plus a tear-free load.
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      goto(c);
      slot($sformatf("idle_c%0d", c), (c < 2) ? 4'b0000 : 4'b0001, (c < 2) ? 8'h00 : 8'h3f);
    end
    do_load(5, 16'h1234, 4'b0100);
    goto(6);  slot("idle_c6", 4'b0001, 8'h3f);
    goto(7);  slot("idle_c7", 4'b0001, 8'h3f);
    goto(10); slot("idle_c10", 4'b0010, 8'h3f);
    goto(26); slot("f0_d3", 4'b1000, 8'h3f);
    goto(34); slot("f1_d0", 4'b0001, 8'h66);
    goto(42); slot("f1_d1", 4'b0010, 8'h4f);
    goto(50); slot("f1_d2", 4'b0100, 8'hdb);
    goto(58); slot("f1_d3", 4'b1000, 8'h06);

    // Double load (last wins) and a load on the boundary cycle.
    do_reset(0);
    do_load(10, 16'h1111, 4'b0000);
    do_load(20, 16'h2222, 4'b0000);
    goto(26); slot("dbl_f0_d3", 4'b1000, 8'h3f);
    goto(34); slot("dbl_f1_d0", 4'b0001, 8'h5b);
    goto(42); slot("dbl_f1_d1", 4'b0010, 8'h5b);
    goto(58); slot("dbl_f1_d3", 4'b1000, 8'h5b);
    do_load(63, 16'h9999, 4'b0000);
    goto(66); slot("bnd_f2_d0", 4'b0001, 8'h67);
    goto(90); slot("bnd_f2_d3", 4'b1000, 8'h67);
    goto(98); slot("bnd_f3_d0", 4'b0001, 8'h67);

    // Masking and invalid BCD codes.
    do_reset(0);
    bus.digit_mask = 4'b1010;
    do_load(0, 16'hF0A5, 4'b0000);
    goto(34); slot("mask_d0", 4'b0000, 8'h00);
    goto(42); slot("mask_d1", 4'b0010, 8'h00);
    goto(50); slot("mask_d2", 4'b0000, 8'h00);
    goto(58); slot("mask_d3", 4'b1000, 8'h00);
    do_load(60, 16'hF0A5, 4'b1000);
    goto(90); slot("mask_dp_d3", 4'b1000, 8'h80);
    goto(93); slot("mask_dp_d3_end", 4'b1000, 8'h80);

    // Mid-frame reset discards a pending load.
    do_reset(0);
    bus.digit_mask = 4'b1111;
    do_load(35, 16'h8888, 4'b0000);
    goto(39); slot("mid_c39", 4'b0001, 8'h3f);
    goto(40);
    rst_n = 1'b0;
    tick();
    slot("mid_rst", 4'b0000, 8'h00);
    chk("mid_rst_frame_done", {7'b0, bus.frame_done}, 8'h00);
    rst_n = 1'b1;
    cyc   = 0;
    slot("mid_c0", 4'b0000, 8'h00);
    goto(2);  slot("mid_c2", 4'b0001, 8'h3f);
    goto(34); slot("mid_f1_d0", 4'b0001, 8'h3f);
    goto(66); slot("mid_f2_d0", 4'b0001, 8'h3f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
